univ_shift_reg: RTL and testbench

Parametrised universal shift register, the successor to the fixed single-bit serial-in/serial-out register. It supports hold, shift-right, shift-left and parallel-load modes, so one block covers SISO, SIPO, PISO and PIPO use. A shift counter and a word-complete strobe let serial links and framers built around it know when a full WIDTH-bit word has moved.

---
 rtl/univ_shift_reg_pkg.sv | 10 +
 rtl/univ_shift_reg_if.sv | 17 +
 rtl/shift_word_counter.sv | 28 ++
 rtl/univ_shift_reg.sv | 43 ++++
 tb/tb_univ_shift_reg.sv | 147 ++++++++++++++
 5 files changed

// File: rtl/univ_shift_reg_pkg.sv
// usr_pkg: mode encodings and width legality check for univ_shift_reg.
package usr_pkg;
  localparam logic [1:0] MODE_HOLD = 2'b00;
  localparam logic [1:0] MODE_SHR  = 2'b01;
  localparam logic [1:0] MODE_SHL  = 2'b10;
  localparam logic [1:0] MODE_LOAD = 2'b11;
  function automatic bit width_ok(input int w);
    return w >= 2 && w <= 64;
  endfunction
endpackage

// File: rtl/univ_shift_reg_if.sv
// univ_shift_reg_if: control, serial and parallel signals of the universal shift register.
interface univ_shift_reg_if #(parameter int WIDTH = 8);
  localparam int CNT_W = $clog2(WIDTH);
  logic             clr;
  logic             en;
  logic [1:0]       mode;
  logic             sin_r;
  logic             sin_l;
  logic [WIDTH-1:0] pin;
  logic [WIDTH-1:0] pout;
  logic             sout_r;
  logic             sout_l;
  logic [CNT_W-1:0] cnt;
  logic             word_done;
  modport master (output clr, en, mode, sin_r, sin_l, pin, input pout, sout_r, sout_l, cnt, word_done);
  modport slave  (input clr, en, mode, sin_r, sin_l, pin, output pout, sout_r, sout_l, cnt, word_done);
endinterface

// File: rtl/shift_word_counter.sv
// shift_word_counter: modulo-WIDTH shift counter with a one-cycle word-complete strobe.
module shift_word_counter #(
  parameter int WIDTH = 8,
  parameter int CNT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             inc,
  input  logic             ld,
  output logic [CNT_W-1:0] cnt,
  output logic             word_done
);
  logic last;
  assign last = cnt == CNT_W'(WIDTH - 1);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      word_done <= 1'b0;
    end else if (clr || ld) begin
      cnt       <= '0;
      word_done <= 1'b0;
    end else begin
      cnt       <= inc ? (last ? '0 : cnt + 1'b1) : cnt;
      word_done <= inc && last;
    end
  end
endmodule

// File: rtl/univ_shift_reg.sv
// univ_shift_reg: hold / shift-right / shift-left / parallel-load register with word counter.
module univ_shift_reg
  import usr_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst_n,
  univ_shift_reg_if.slave bus
);
  localparam int CNT_W = $clog2(WIDTH);
  if (!width_ok(WIDTH)) begin : g_bad_width
    $error("univ_shift_reg: WIDTH must be 2..64");
  end
  logic [WIDTH-1:0] q;
  logic [WIDTH-1:0] q_nxt;
  logic             shift;
  logic             load;
  always_comb begin
    q_nxt = bus.mode == MODE_SHR  ? {bus.sin_r, q[WIDTH-1:1]} :
            bus.mode == MODE_SHL  ? {q[WIDTH-2:0], bus.sin_l} :
            bus.mode == MODE_LOAD ? bus.pin : q;
    shift = bus.en && (bus.mode == MODE_SHR || bus.mode == MODE_SHL);
    load  = bus.en && bus.mode == MODE_LOAD;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) q <= '0;
    else if (bus.clr) q <= '0;
    else if (bus.en) q <= q_nxt;
  end
  shift_word_counter #(.WIDTH(WIDTH), .CNT_W(CNT_W)) u_cnt (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (bus.clr),
    .inc      (shift),
    .ld       (load),
    .cnt      (bus.cnt),
    .word_done(bus.word_done)
  );
  assign bus.pout   = q;
  assign bus.sout_r = q[0];
  assign bus.sout_l = q[WIDTH-1];
endmodule

// File: tb/tb_univ_shift_reg.sv
// tb_univ_shift_reg: table-driven vectors plus hand sequences, checked through an expected-result queue.
module tb_univ_shift_reg;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  univ_shift_reg_if #(.WIDTH(8)) bus ();
  univ_shift_reg #(.WIDTH(8)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));
  typedef struct {
    logic       clr;
    logic       en;
    logic [1:0] mode;
    logic       sr;
    logic       sl;
    logic [7:0] pin;
    logic [7:0] q;
    logic [2:0] cnt;
    logic       wd;
  } vec_t;
  typedef struct {
    logic [7:0] q;
    logic [2:0] cnt;
    logic       wd;
  } exp_t;
  vec_t tbl[$];
  exp_t sb[$];
  int checks = 0;
  int errors = 0;
  task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  function automatic void add(input logic c, input logic e, input logic [1:0] m, input logic r,
                              input logic l, input logic [7:0] p, input logic [7:0] q,
                              input logic [2:0] n, input logic w);
    tbl.push_back('{c, e, m, r, l, p, q, n, w});
  endfunction
  task automatic step(input vec_t v, input string tag);
    exp_t e;
    bus.clr = v.clr; bus.en = v.en; bus.mode = v.mode;
    bus.sin_r = v.sr; bus.sin_l = v.sl; bus.pin = v.pin;
    sb.push_back('{v.q, v.cnt, v.wd});
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      checks++; errors++;
      $display("FAIL %s: scoreboard empty", tag);
    end else begin
      e = sb.pop_front();
      chk({tag, " pout"}, bus.pout, e.q);
      chk({tag, " cnt"}, 8'(bus.cnt), 8'(e.cnt));
      chk({tag, " word_done"}, 8'(bus.word_done), 8'(e.wd));
      chk({tag, " sout_r"}, 8'(bus.sout_r), 8'(e.q[0]));
      chk({tag, " sout_l"}, 8'(bus.sout_l), 8'(e.q[7]));
    end
  endtask
  task automatic async_reset(input string tag);
    #3 rst_n = 1'b0;
    #1;
    chk({tag, " pout"}, bus.pout, 8'h00);
    chk({tag, " cnt"}, 8'(bus.cnt), 8'h00);
    chk({tag, " word_done"}, 8'(bus.word_done), 8'h00);
    #1 rst_n = 1'b1;
  endtask
  initial begin
    vec_t v;
    bus.clr = 0; bus.en = 0; bus.mode = 2'b00; bus.sin_r = 0; bus.sin_l = 0; bus.pin = 8'h00;
    #2;
    chk("power-on reset pout", bus.pout, 8'h00);
    chk("power-on reset cnt", 8'(bus.cnt), 8'h00);
    chk("power-on reset word_done", 8'(bus.word_done), 8'h00);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;
    // PISO of 0xA5
    add(0,1,2'b11,0,0,8'hA5, 8'hA5,0,0);
    add(0,1,2'b01,0,0,8'h00, 8'h52,1,0);
    add(0,1,2'b01,0,0,8'h00, 8'h29,2,0);
    add(0,1,2'b01,0,0,8'h00, 8'h14,3,0);
    add(0,1,2'b01,0,0,8'h00, 8'h0A,4,0);
    add(0,1,2'b01,0,0,8'h00, 8'h05,5,0);
    add(0,1,2'b01,0,0,8'h00, 8'h02,6,0);
    add(0,1,2'b01,0,0,8'h00, 8'h01,7,0);
    add(0,1,2'b01,0,0,8'h00, 8'h00,0,1);
    add(0,1,2'b00,0,0,8'h00, 8'h00,0,0);
    // SIPO with sin_l = 1,0,1,1,0,0,1,0
    add(1,0,2'b00,0,0,8'h00, 8'h00,0,0);
    add(0,1,2'b10,0,1,8'h00, 8'h01,1,0);
    add(0,1,2'b10,0,0,8'h00, 8'h02,2,0);
    add(0,1,2'b10,0,1,8'h00, 8'h05,3,0);
    add(0,1,2'b10,0,1,8'h00, 8'h0B,4,0);
    add(0,1,2'b10,0,0,8'h00, 8'h16,5,0);
    add(0,1,2'b10,0,0,8'h00, 8'h2C,6,0);
    add(0,1,2'b10,0,1,8'h00, 8'h59,7,0);
    add(0,1,2'b10,0,0,8'h00, 8'hB2,0,1);
    add(0,1,2'b00,0,0,8'h00, 8'hB2,0,0);
    // clr beats a simultaneous load
    add(1,1,2'b11,0,0,8'hFF, 8'h00,0,0);
    // enable and hold, then a shift in the other direction still counts
    add(0,1,2'b01,1,0,8'h00, 8'h80,1,0);
    add(0,1,2'b01,1,0,8'h00, 8'hC0,2,0);
    add(0,1,2'b01,0,0,8'h00, 8'h60,3,0);
    for (int i = 0; i < 5; i++) add(0,0,2'b01,1,1,8'h00, 8'h60,3,0);
    for (int i = 0; i < 2; i++) add(0,1,2'b00,1,1,8'h00, 8'h60,3,0);
    add(0,0,2'b11,0,0,8'hFF, 8'h60,3,0);
    add(0,1,2'b10,0,1,8'h00, 8'hC1,4,0);
    // SISO: a single 1 reaches sout_r after exactly 8 shifts
    add(1,1,2'b01,0,0,8'h00, 8'h00,0,0);
    add(0,1,2'b01,1,0,8'h00, 8'h80,1,0);
    add(0,1,2'b01,0,0,8'h00, 8'h40,2,0);
    add(0,1,2'b01,0,0,8'h00, 8'h20,3,0);
    add(0,1,2'b01,0,0,8'h00, 8'h10,4,0);
    add(0,1,2'b01,0,0,8'h00, 8'h08,5,0);
    add(0,1,2'b01,0,0,8'h00, 8'h04,6,0);
    add(0,1,2'b01,0,0,8'h00, 8'h02,7,0);
    add(0,1,2'b01,0,0,8'h00, 8'h01,0,1);
    add(0,1,2'b01,0,0,8'h00, 8'h00,1,0);
    foreach (tbl[i]) step(tbl[i], $sformatf("vec%0d", i));
    // asynchronous reset between edges with a non-zero state
    v = '{0,1,2'b11,0,0,8'h3C, 8'h3C,0,0}; step(v, "pre-reset load");
    v = '{0,1,2'b01,0,0,8'h00, 8'h1E,1,0}; step(v, "pre-reset shift");
    async_reset("async reset");
    // mid-word reset discards a partial word
    for (int i = 1; i <= 5; i++) begin
      v = '{0,1,2'b01,1,0,8'h00, 8'(8'hFF << (8 - i)), 3'(i), 0};
      step(v, $sformatf("pre-reset shr%0d", i));
    end
    async_reset("mid-word reset");
    for (int i = 1; i <= 8; i++) begin
      v = '{0,1,2'b01,0,0,8'h00, 8'h00, 3'(i % 8), logic'(i == 8)};
      step(v, $sformatf("post-reset shr%0d", i));
    end
    v = '{0,1,2'b00,0,0,8'h00, 8'h00,0,0}; step(v, "strobe drop");
    if (sb.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard drain: %0d left expected 0", sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
  initial begin
    #50000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end
endmodule
